// File: rtl/mem_pkg.sv
// Shared definitions for the load path: funct3 codes, fault codes, FSM states.
// Helper functions classify a load's funct3 so decode lives in one place.
package mem_pkg;

  localparam int MEM_BYTES_DEF = 512;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_RANGE    = 2'd2;
  localparam logic [1:0] FLT_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Access size in bytes; 0 marks an illegal funct3.
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: access_size = 3'd1;
      F3_LH, F3_LHU: access_size = 3'd2;
      F3_LW:         access_size = 3'd4;
      default:       access_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a big-endian RAM word.
// Only the leading lanes are looked at, so trailing X lanes never leak out.
module load_extract
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:  result = {{24{word[31]}}, word[31:24]};
      F3_LBU: result = {24'd0, word[31:24]};
      F3_LH:  result = {{16{word[31]}}, word[31:16]};
      F3_LHU: result = {16'd0, word[31:16]};
      F3_LW:  result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// RV32E load stage: address generation and checking, one-cycle RAM read,
// extraction, and a valid/ready response. Faulting loads skip the RAM entirely.
module mem_load_unit
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_base,
  input  logic [11:0]       req_offset,
  input  logic [2:0]        req_funct3,
  input  logic [3:0]        req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [3:0]        rsp_rd,
  output logic [1:0]        rsp_fault
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [3:0]        rsp_rd_q, rsp_rd_d;
  logic [1:0]        rsp_fault_q, rsp_fault_d;

  logic [31:0] ea;
  logic [2:0]  size;
  logic [32:0] limit;
  logic [1:0]  fault;
  logic [31:0] ext_data;

  assign ea    = req_base + {{20{req_offset[11]}}, req_offset};
  assign size  = access_size(req_funct3);
  assign limit = 33'(MEM_BYTES) - {30'd0, size};

  // Wrapped sums are compared unsigned exactly as formed.
  always_comb begin
    fault = FLT_NONE;
    if (size == 3'd0)
      fault = FLT_ILLEGAL;
    else if ((size == 3'd2 && ea[0]) || (size == 3'd4 && ea[1:0] != 2'b00))
      fault = FLT_MISALIGN;
    else if ({1'b0, ea} > limit)
      fault = FLT_RANGE;
  end

  load_extract u_extract (
    .funct3 (f3_q),
    .word   (mem_rdata),
    .result (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    f3_d        = f3_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          f3_d        = req_funct3;
          rsp_rd_d    = req_rd;
          rsp_fault_d = fault;
          if (fault == FLT_NONE) begin
            mem_addr_d = ADDR_W'(ea);
            state_d    = ST_READ;
          end else begin
            rsp_data_d  = '0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_READ: begin
        rsp_data_d  = ext_data;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      f3_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_fault_q <= FLT_NONE;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      f3_q        <= f3_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit with a big-endian RAM model and a scoreboard
// of expected responses, including latency, stall, fault and reset cases.
module tb_mem_load_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [2:0]  req_funct3;
  logic [3:0]  req_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_rd;
  logic [1:0]  rsp_fault;

  int tests_run;
  int tests_failed;

  logic [7:0]  ram [512];
  logic [31:0] last_addr;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  rd;
    logic [1:0]  fault;
    int          lat;
  } exp_t;
  exp_t sb[$];

  mem_load_unit #(.MEM_BYTES(512), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_funct3 (req_funct3),
    .req_rd     (req_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_fault  (rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rb(input logic [32:0] a);
    if (a < 33'd512) return ram[a[8:0]];
    return 8'hxx;
  endfunction

  always_comb begin
    mem_rdata = {rb({1'b0, mem_addr}), rb({1'b0, mem_addr} + 33'd1),
                 rb({1'b0, mem_addr} + 33'd2), rb({1'b0, mem_addr} + 33'd3)};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge, idle again.
  task automatic load(input logic [31:0] base, input logic [11:0] off, input logic [2:0] f3,
                      input logic [3:0] rd, input logic [31:0] edata, input logic [1:0] efault,
                      input int hold);
    exp_t e;
    exp_t got;
    logic [31:0] ea;
    int n;
    ea = base + {{20{off[11]}}, off};
    e.data = edata; e.rd = rd; e.fault = efault; e.lat = (efault == 2'd0) ? 2 : 1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_base = base; req_offset = off; req_funct3 = f3; req_rd = rd;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (efault == 2'd0) last_addr = ea;
    chk("mem_addr", mem_addr, last_addr);
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    got = sb.pop_front();
    chk("latency", n, got.lat);
    chk("rsp_data", rsp_data, got.data);
    chk("rsp_rd", {28'd0, rsp_rd}, {28'd0, got.rd});
    chk("rsp_fault", {30'd0, rsp_fault}, {30'd0, got.fault});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, got.data);
      chk("hold_rd", {28'd0, rsp_rd}, {28'd0, got.rd});
      chk("hold_fault", {30'd0, rsp_fault}, {30'd0, got.fault});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("mem_addr_hold", mem_addr, last_addr);
  endtask

  task automatic chk_reset_state();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_rd", {28'd0, rsp_rd}, 32'd0);
    chk("rst_rsp_fault", {30'd0, rsp_fault}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    ram[0] = 8'hCA; ram[1] = 8'hC0; ram[2] = 8'hCA; ram[3] = 8'hFE;
    last_addr = 32'd0;
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_base = '0; req_offset = '0; req_funct3 = '0; req_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    reset_n = 1'b1;
    @(negedge clk);

    load(32'd0,   12'd0,     3'd2, 4'd5,  32'hCAC0CAFE, 2'd0, 0);
    load(32'd1,   12'd0,     3'd0, 4'd1,  32'hFFFFFFC0, 2'd0, 0);
    load(32'd1,   12'd0,     3'd4, 4'd2,  32'h000000C0, 2'd0, 0);
    load(32'd2,   12'd0,     3'd1, 4'd3,  32'hFFFFCAFE, 2'd0, 0);
    load(32'd0,   12'd0,     3'd5, 4'd4,  32'h0000CAC0, 2'd0, 0);
    load(32'd4,   12'hFFD,   3'd0, 4'd6,  32'hFFFFFFC0, 2'd0, 0);
    load(32'd508, 12'd0,     3'd2, 4'd7,  32'h00000000, 2'd0, 0);
    load(32'd0,   12'd2,     3'd2, 4'd8,  32'h00000000, 2'd1, 0);
    load(32'd512, 12'd0,     3'd0, 4'd9,  32'h00000000, 2'd2, 0);
    load(32'd2,   12'd0,     3'd3, 4'd10, 32'h00000000, 2'd3, 0);
    load(32'hFFFFFFFF, 12'd0, 3'd0, 4'd11, 32'h00000000, 2'd2, 0);
    load(32'd511, 12'd0,     3'd5, 4'd12, 32'h00000000, 2'd1, 0);
    load(32'd1000, 12'd1,    3'd7, 4'd13, 32'h00000000, 2'd3, 0);
    load(32'd510, 12'd0,     3'd1, 4'd14, 32'h00000000, 2'd0, 0);
    load(32'd0,   12'd0,     3'd2, 4'd15, 32'hCAC0CAFE, 2'd0, 3);
    load(32'd3,   12'd0,     3'd4, 4'd1,  32'h000000FE, 2'd0, 0);
    load(32'd0,   12'd2,     3'd2, 4'd2,  32'h00000000, 2'd1, 2);

    // Reset while a good load sits in READ: nothing may come out.
    req_valid = 1'b1; req_base = 32'd0; req_offset = 12'd0; req_funct3 = 3'd2; req_rd = 4'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_mem_addr", mem_addr, 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    reset_n = 1'b1;
    last_addr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    load(32'd0, 12'd0, 3'd0, 4'd3, 32'hFFFFFFCA, 2'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
